// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: state encoding and bus constants shared by the RAM DMA master slice
//   S_*        : FSM state codes (IDLE, REQ, RD, RWAIT, WR, DONE)
//   WORD_BYTES : byte stride between consecutive 32-bit words
//   ZERO_WORD  : value driven on unused data lines
package ram_dma_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_REQ   = 3'd1;
  localparam state_t S_RD    = 3'd2;
  localparam state_t S_RWAIT = 3'd3;
  localparam state_t S_WR    = 3'd4;
  localparam state_t S_DONE  = 3'd5;
  localparam int WORD_BYTES = 4;
  localparam logic [31:0] ZERO_WORD = 32'h0;
endpackage

// File: rtl/ram_dma_addr_gen.sv
// ram_dma_addr_gen: current source/destination addresses and remaining word count
//   clk, rst        : clock, asynchronous active-low reset
//   load            : latch src/dst/len for a new transfer
//   step            : advance both addresses by one word and consume one count
//   src, dst, len   : transfer parameters sampled on load
//   cur_src/cur_dst : addresses of the word in flight (wrap modulo 2^ADDR_W)
//   last            : the word in flight is the final one (count hits zero on this step)
module ram_dma_addr_gen
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] cur_src,
  output logic [ADDR_W-1:0] cur_dst,
  output logic              last
);
  logic [LEN_W-1:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur_src <= '0;
      cur_dst <= '0;
      count   <= '0;
    end else if (load) begin
      cur_src <= src;
      cur_dst <= dst;
      count   <= len;
    end else if (step) begin
      cur_src <= cur_src + ADDR_W'(WORD_BYTES);
      cur_dst <= cur_dst + ADDR_W'(WORD_BYTES);
      count   <= count - 1'b1;
    end
  assign last = count == LEN_W'(1);
endmodule

// File: rtl/ram_dma_master.sv
// ram_dma_master: bus initiator copying LEN words from src to dst through the RAM data port
//   clk, rst          : clock, asynchronous active-low reset
//   start             : one-cycle request, honoured only when idle
//   src, dst, len     : word-aligned byte addresses and word count
//   bus_req, bus_gnt  : data-bus arbitration handshake
//   de, drw, daddr,
//   din, dout         : RAM data port (all driven zero while de is low)
//   busy, done, err   : transfer in progress, completion pulse, rejected-start pulse
//   DMA_FILL_EN       : when defined adds fill/pattern inputs to write a constant
//                       pattern to dst words without reading the source
module ram_dma_master
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [31:0]       pattern,
`endif
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              de,
  output logic              drw,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       din,
  input  logic [31:0]       dout,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_t            state;
  logic [31:0]       data;
  logic [1:0]        wcnt;
  logic              fill_r;
  logic              fill_go;
  logic              aligned;
  logic              accept;
  logic              last;
  logic [ADDR_W-1:0] cur_src;
  logic [ADDR_W-1:0] cur_dst;
`ifdef DMA_FILL_EN
  assign fill_go = fill;
`else
  assign fill_go = 1'b0;
`endif
  // a fill never touches the source, so its alignment is irrelevant
  assign aligned = dst[1:0] == 2'b00 && (fill_go || src[1:0] == 2'b00);
  assign accept  = state == S_IDLE && start && aligned && len != '0;
  ram_dma_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_addr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .step   (state == S_WR),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .cur_src(cur_src),
    .cur_dst(cur_dst),
    .last   (last)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state  <= S_IDLE;
      data   <= ZERO_WORD;
      wcnt   <= '0;
      fill_r <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= state == S_IDLE && start && !aligned;
      case (state)
        S_IDLE: if (start) begin
          state  <= !aligned ? S_IDLE : len == '0 ? S_DONE : S_REQ;
          fill_r <= fill_go;
`ifdef DMA_FILL_EN
          if (fill) data <= pattern;
`endif
        end
        S_REQ: if (bus_gnt) state <= fill_r ? S_WR : S_RD;
        // losing the grant mid-read drops the word; it is re-read from cur_src later
        S_RD: if (!bus_gnt) state <= S_REQ;
        else if (RD_LAT == 0) begin
          data  <= dout;
          state <= S_WR;
        end else begin
          wcnt  <= 2'(RD_LAT - 1);
          state <= S_RWAIT;
        end
        S_RWAIT: if (!bus_gnt) state <= S_REQ;
        else if (wcnt == 2'd0) begin
          data  <= dout;
          state <= S_WR;
        end else wcnt <= wcnt - 2'd1;
        // the write itself is atomic; arbitration is only rechecked before the next word
        S_WR: state <= last ? S_DONE : !bus_gnt ? S_REQ : fill_r ? S_WR : S_RD;
        default: state <= S_IDLE;
      endcase
    end
  assign busy    = state inside {S_REQ, S_RD, S_RWAIT, S_WR};
  assign bus_req = busy;
  assign done    = state == S_DONE;
  assign de      = state inside {S_RD, S_RWAIT, S_WR};
  assign drw     = state == S_WR;
  assign daddr   = drw ? cur_dst : de ? cur_src : '0;
  assign din     = drw ? data : ZERO_WORD;
endmodule

// File: tb/tb_ram_dma_master.sv
// tb_ram_dma_master: directed bench with a transfer-level model and per-cycle bus checking
module tb_ram_dma_master;
  localparam int RD_LAT = 1;
  logic        clk = 0, rst = 0, start = 0, bus_gnt = 1;
  logic [31:0] src = 0, dst = 0;
  logic [15:0] len = 0;
`ifdef DMA_FILL_EN
  logic        fill = 0;
  logic [31:0] pattern = 0;
`endif
  logic        bus_req, de, drw, busy, done, err;
  logic [31:0] daddr, din, dout;
  logic [31:0] mem [0:1023];
  int          total = 0, bad = 0;
  bit          job_active = 0, job_fill = 0, exp_zero_done = 0, exp_err = 0, done_due = 0;
  logic [31:0] job_src = 0, job_dst = 0;
  int          job_len = 0, wdone = 0;
  logic [31:0] exp_q [$];
  int          de_cycles = 0, watch_hits = 0, n_done = 0;
  logic [31:0] watch_addr = 32'hFFFF_FFFF;
  logic        gnt_at_edge = 1;

  ram_dma_master #(.ADDR_W(32), .LEN_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
`ifdef DMA_FILL_EN
    .fill(fill), .pattern(pattern),
`endif
    .bus_req(bus_req), .bus_gnt(bus_gnt), .de(de), .drw(drw), .daddr(daddr),
    .din(din), .dout(dout), .busy(busy), .done(done), .err(err)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // block RAM with one cycle of read latency; source words 0x100.. and 0x300.. preloaded
  initial begin
    dout <= '0;
    for (int i = 0; i < 1024; i++)
      mem[i] <= (i >= 'h40 && i < 'h44) ? 32'(32'hA0 + i - 'h40) :
                (i >= 'hC0 && i < 'hC3) ? 32'(32'hB0 + i - 'hC0) : 32'h0;
    forever begin
      @(posedge clk);
      if (de && drw) mem[daddr[11:2]] <= din;
      if (de && !drw) dout <= mem[daddr[11:2]];
    end
  end

  initial forever begin
    @(posedge clk);
    gnt_at_edge <= bus_gnt;
  end

  // transfer-level model: word i of a job reads src+4i then writes the source word to dst+4i
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_de", de, 0);
      chk("rst_req", bus_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      done_due = 0;
      exp_zero_done = 0;
      exp_err = 0;
    end else begin
      chk("req_eq_busy", bus_req, busy);
      chk("done_pulse", done, done_due || exp_zero_done);
      chk("err_pulse", err, exp_err);
      done_due = 0;
      exp_zero_done = 0;
      exp_err = 0;
      if (done) n_done++;
      chk("de_without_gnt", de && !gnt_at_edge, 0);
      if (!de) begin
        chk("idle_addr", daddr, 0);
        chk("idle_din", din, 0);
        chk("idle_drw", drw, 0);
      end else begin
        de_cycles++;
        if (!job_active) chk("bus_without_job", de, 0);
        else if (drw) begin
          chk("wr_addr", daddr, job_dst + 32'(4 * wdone));
          chk("wr_data", din, exp_q[wdone]);
          wdone++;
          if (wdone == job_len) begin
            job_active = 0;
            done_due = 1;
          end
        end else if (job_fill) chk("read_in_fill", drw, 1);
        else begin
          if (daddr == watch_addr) watch_hits++;
          chk("rd_addr", daddr, job_src + 32'(4 * wdone));
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input bit f, input bit ignore);
    @(posedge clk); #1;
    start = 1; src = s; dst = d; len = l;
`ifdef DMA_FILL_EN
    fill = f; pattern = 32'hDEADBEEF;
`endif
    @(posedge clk); #1;
    start = 0;
    if (ignore) return;
    if (d[1:0] != 2'b00 || (!f && s[1:0] != 2'b00)) exp_err = 1;
    else if (l == 0) exp_zero_done = 1;
    else begin
      exp_q.delete();
      for (int i = 0; i < int'(l); i++)
        exp_q.push_back(f ? 32'hDEADBEEF : mem[10'((s >> 2) + 32'(i))]);
      job_src = s; job_dst = d; job_len = int'(l); wdone = 0; job_fill = f; job_active = 1;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!done && cyc < 100);
    chk("done_seen", done, 1);
  endtask

  initial begin
    int cyc, snap, exp_n;
    exp_n = 5;
    repeat (3) @(posedge clk); #1;
    chk("reset_de", de, 0);
    chk("reset_req", bus_req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_daddr", daddr, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    rst = 1;

    do_start(32'h100, 32'h200, 4, 0, 0);
    wait_done(cyc);
    chk("copy_latency", cyc, 13);
    chk("busy_falls_with_done", busy, 0);
    for (int i = 0; i < 4; i++) chk("copy_mem", mem[10'('h80 + i)], 32'(32'hA0 + i));

    snap = de_cycles;
    do_start(32'h100, 32'h202, 4, 0, 0);
    chk("misalign_err", err, 1);
    chk("misalign_busy", busy, 0);
    repeat (5) @(posedge clk); #1;
    chk("misalign_no_bus", de_cycles, snap);
    chk("misalign_busy_after", busy, 0);

    watch_addr = 32'h304;
    do_start(32'h300, 32'h400, 3, 0, 0);
    repeat (5) @(posedge clk); #1;
    chk("rwait_de", de, 1);
    chk("rwait_drw", drw, 0);
    chk("rwait_addr", daddr, 32'h304);
    bus_gnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("revoke_de", de, 0);
      chk("revoke_req", bus_req, 1);
    end
    bus_gnt = 1;
    wait_done(cyc);
    chk("reread_cycles", watch_hits, 4);
    for (int i = 0; i < 3; i++) chk("grant_mem", mem[10'('h100 + i)], 32'(32'hB0 + i));

    do_start(32'h100, 32'h600, 4, 0, 0);
    repeat (3) @(posedge clk); #1;
    chk("wr1_de", de, 1);
    chk("wr1_drw", drw, 1);
    chk("wr1_addr", daddr, 32'h600);
    #2 rst = 0; job_active = 0;
    #1;
    chk("async_de", de, 0);
    chk("async_req", bus_req, 0);
    chk("async_busy", busy, 0);
    repeat (2) @(posedge clk); #1;
    rst = 1;
    chk("no_write_after_rst", mem[10'h180], 0);
    do_start(32'h100, 32'h700, 2, 0, 0);
    wait_done(cyc);
    chk("post_rst_latency", cyc, 7);
    for (int i = 0; i < 2; i++) chk("post_rst_mem", mem[10'('h1C0 + i)], 32'(32'hA0 + i));

    snap = de_cycles;
    do_start(32'h100, 32'h800, 0, 0, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_req", bus_req, 0);
    @(posedge clk); #1;
    chk("zero_done_once", done, 0);
    chk("zero_no_bus", de_cycles, snap);

    do_start(32'h100, 32'h900, 4, 0, 0);
    repeat (2) @(posedge clk); #1;
    do_start(32'h300, 32'hA00, 1, 0, 1);
    wait_done(cyc);
    for (int i = 0; i < 4; i++) chk("busy_mem", mem[10'('h240 + i)], 32'(32'hA0 + i));
    chk("ignored_start_mem", mem[10'h280], 0);

`ifdef DMA_FILL_EN
    exp_n = 6;
    do_start(32'h3, 32'h0, 8, 1, 0);
    wait_done(cyc);
    chk("fill_latency", cyc, 9);
    for (int i = 0; i < 8; i++) chk("fill_mem", mem[i], 32'hDEADBEEF);
`endif

    @(posedge clk); #1;
    chk("done_count", n_done, exp_n);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_dma_master.md
Name: ram_dma_master

Overview:
- Bus initiator that drives the data-side port of the block-RAM module (de, daddr, drw, din; dout returned).
- Copies LEN 32-bit words from a source to a destination word address. It can be used by the boot path (image staging) or started by the CPU.
- Sits beside the CPU on the data bus. It requests the bus, waits for a grant, then issues read/write word pairs.
- Idle outputs are held at zero, matching the bus rule that unused signals go low.

Parameters:
- ADDR_W, 32, byte-address width on the bus.
- LEN_W, 16, width of the word-count register; max transfer is 2^LEN_W-1 words.
- RD_LAT, 1, cycles from a read address being presented (de=1, drw=0) to dout being valid; legal range 0..3.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- src  in  ADDR_W  source byte address; must be word-aligned.
- dst  in  ADDR_W  destination byte address; must be word-aligned.
- len  in  LEN_W  number of words to copy.
- bus_req  out  1  request for the data bus.
- bus_gnt  in  1  bus granted by the arbiter.
- de  out  1  data enable to RAM.
- drw  out  1  1 = write, 0 = read.
- daddr  out  ADDR_W  RAM byte address.
- din  out  32  write data to RAM.
- dout  in  32  read data from RAM.
- busy  out  1  high from start acceptance until DONE/ERR exits.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - bus_req, de, drw, daddr, din, busy, done, err all 0.
  - Internal src/dst/count registers cleared.
- Start acceptance:
  - start in IDLE with len!=0 and src[1:0]==dst[1:0]==0: latch src, dst, len; busy=1; bus_req=1; go to REQ.
  - start in IDLE with misalignment: err pulses 1 cycle next edge; stay IDLE.
  - start in IDLE with len==0: done pulses 1 cycle next edge; no bus activity.
  - start outside IDLE is ignored.
- States: IDLE, REQ, RD, RWAIT, WR, DONE.
- REQ: wait for bus_gnt=1, then go to RD.
- RD (1 cycle): de=1, drw=0, daddr=cur_src.
  - RD_LAT==0: capture dout this cycle, go to WR.
  - Otherwise go to RWAIT.
- RWAIT: hold de=1, drw=0, daddr=cur_src for RD_LAT cycles (down-counter). Capture dout into the data register on the last cycle, then go to WR.
- WR (1 cycle): de=1, drw=1, daddr=cur_dst, din=data register.
  - Then cur_src+=4, cur_dst+=4, count-=1.
  - count reaches 0: go to DONE. Otherwise go to RD.
- DONE: done=1 for 1 cycle; busy=0 and bus_req=0 on the same edge; return to IDLE.
- Whenever de=0, daddr, drw and din are driven 0.
- Grant loss:
  - bus_gnt falling in RD or RWAIT: abandon the read (de=0 from next edge) and return to REQ. The read restarts from cur_src; the captured word is discarded.
  - bus_gnt falling during WR: the write cycle in flight completes (1-cycle atomic). The FSM then goes to REQ before the next RD.
- Address wrap: cur_src/cur_dst wrap modulo 2^ADDR_W with no error.
- Reset mid-transfer: bus released immediately (de=0, bus_req=0); no done pulse.
- Throughput: 2+RD_LAT cycles per word with continuous grant.

Optional Feature:
- Macro DMA_FILL_EN.
- When defined: add input port `fill` (1 bit) and input `pattern` (32 bits), both sampled at start.
  - fill=1 skips RD/RWAIT; every WR writes `pattern` to consecutive dst words, 1 cycle per word; src is ignored and its alignment is not checked.
- When undefined: neither port exists; behaviour is copy-only as above.

Decomposition:
- Package ram_dma_pkg:
  - State enum type.
  - WORD_BYTES=4 constant.
  - Zero-word constant for idle bus drive.
- One sub-module, ram_dma_addr_gen: holds cur_src, cur_dst and count registers, with load, step and zero-flag outputs.
- FSM and bus drive stay in the top module.

Test Plan:
- Copy with RD_LAT=1: src=0x100, dst=0x200, len=4, gnt tied 1. RAM preloaded 0xA0..0xA3 → dst words 0x200..0x20C hold 0xA0..0xA3; done pulses at cycle 13 after start; busy falls with it.
- Misaligned start: dst=0x202 → err pulses once; de never asserts; busy stays 0.
- Grant revoked: bus_gnt=0 for 3 cycles mid-RWAIT of word 2, len=3 → de=0 during revoke; word 2 re-read from the same address; final memory correct.
- Reset mid-transfer: rst=0 during WR of word 1 → de, bus_req and busy low asynchronously; no done pulse. A new start after release copies correctly.
- len=0 → single done pulse, zero bus cycles. start while busy → ignored; counts unchanged.
- DMA_FILL_EN defined: fill=1, pattern=0xDEADBEEF, dst=0x0, len=8 → 8 consecutive write cycles; words 0x00..0x1C = 0xDEADBEEF; no read cycles observed.
